// File: rtl/tx_nco_pkg.sv
// TX NCO shared definitions: tune FSM states and default widths.
// Imported by the tune controller, its ramp helper and the TX top level.
package tx_nco_pkg;

   localparam int APR_DEF        = 32;
   localparam int SETTLE_CYC_DEF = 12;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RAMP,
      ST_SETTLE
   } tune_state_e;

endpackage

// File: rtl/tx_nco_ramp_step.sv
// One ramp step toward target: moves cur by step, clamping onto target.
// Ports: cur_i/target_i/step_i (APR) in; next_o (APR), last_o out.
module tx_nco_ramp_step
   import tx_nco_pkg::*;
#(
   parameter int APR = APR_DEF
) (
   input  logic [APR-1:0] cur_i,
   input  logic [APR-1:0] target_i,
   input  logic [APR-1:0] step_i,
   output logic [APR-1:0] next_o,
   output logic           last_o
);

   // One extra bit keeps the difference signed without any wrap through 0.
   logic signed [APR:0] diff;
   logic        [APR:0] mag;

   assign diff = $signed({1'b0, target_i}) - $signed({1'b0, cur_i});
   assign mag  = diff[APR] ? $unsigned(-diff) : $unsigned(diff);

   assign last_o = (mag <= {1'b0, step_i});

   always_comb begin
      next_o = target_i;
      if (!last_o) begin
         next_o = diff[APR] ? (cur_i - step_i) : (cur_i + step_i);
      end
   end

endmodule

// File: rtl/tx_nco_tune_ctrl.sv
// TX NCO tuning controller: accepts FTW commands, ramps the phase increment
// linearly to the target, waits out NCO latency and then flags locked.
// Ports: clk, reset_n, ce_i, cfg_valid/cfg_ready/cfg_ftw/cfg_step (host),
//        nco_clken/nco_phi_inc/nco_out_valid (NCO), busy, locked (status).
module tx_nco_tune_ctrl
   import tx_nco_pkg::*;
#(
   parameter int APR        = APR_DEF,
   parameter int SETTLE_CYC = SETTLE_CYC_DEF,
   parameter int CNT_W      = 4
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           ce_i,
   input  logic           cfg_valid,
   output logic           cfg_ready,
   input  logic [APR-1:0] cfg_ftw,
   input  logic [APR-1:0] cfg_step,
   output logic           nco_clken,
   output logic [APR-1:0] nco_phi_inc,
   input  logic           nco_out_valid,
   output logic           busy,
   output logic           locked
);

   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   tune_state_e      state_q, state_d;
   logic [APR-1:0]   tgt_q, tgt_d;
   logic [APR-1:0]   step_q, step_d;
   logic [APR-1:0]   phi_q, phi_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             lock_q, lock_d;
   logic             rdy_q;
   logic             run_q;

   logic [APR-1:0]   ramp_nxt;
   logic             ramp_last;
   logic             accept;

   tx_nco_ramp_step #(
      .APR (APR)
   ) u_step (
      .cur_i    (phi_q),
      .target_i (tgt_q),
      .step_i   (step_q),
      .next_o   (ramp_nxt),
      .last_o   (ramp_last)
   );

   assign accept = cfg_valid & rdy_q;

   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      step_d  = step_q;
      phi_d   = phi_q;
      cnt_d   = cnt_q;
      lock_d  = lock_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               tgt_d  = cfg_ftw;
               step_d = cfg_step;
               lock_d = 1'b0;
               if (cfg_step == '0 || cfg_ftw == phi_q) begin
                  phi_d   = cfg_ftw;
                  cnt_d   = SETTLE_LD;
                  state_d = ST_SETTLE;
               end else begin
                  state_d = ST_RAMP;
               end
            end
         end
         ST_RAMP: begin
            if (ce_i) begin
               phi_d = ramp_nxt;
               if (ramp_last) begin
                  cnt_d   = SETTLE_LD;
                  state_d = ST_SETTLE;
               end
            end
         end
         ST_SETTLE: begin
            // Only samples the NCO actually produced count toward settling.
            if (ce_i && nco_out_valid) begin
               if (cnt_q == CNT_ONE) begin
                  state_d = ST_IDLE;
                  lock_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         tgt_q   <= '0;
         step_q  <= '0;
         phi_q   <= '0;
         cnt_q   <= '0;
         lock_q  <= 1'b0;
         rdy_q   <= 1'b0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         step_q  <= step_d;
         phi_q   <= phi_d;
         cnt_q   <= cnt_d;
         lock_q  <= lock_d;
         run_q   <= 1'b1;
         // Tracks next state so ready drops on the accept edge itself.
         rdy_q   <= (state_d == ST_IDLE);
      end
   end

   assign cfg_ready   = rdy_q;
   assign nco_clken   = ce_i & run_q;
   assign nco_phi_inc = phi_q;
   assign busy        = (state_q != ST_IDLE);
   assign locked      = lock_q;

endmodule
